// File: rtl/pb_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, per-channel counter debouncer, and press/release pulses.
// Optional auto-repeat on held buttons when PB_AUTOREPEAT_EN is defined.
// "release" is a reserved word, so that output is named release_pulse.
module pb_conditioner #(
  parameter int unsigned NBTN         = 21,
  parameter int unsigned DB_TICKS     = 3,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] pb_in,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] release_pulse,
  output logic            any_held
);

  if (DB_TICKS < 1 || DB_TICKS >= 2 ** CNT_W || REPEAT_RATE == 0 ||
      REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
    $error("pb_conditioner: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_TICKS - 1);

  logic [NBTN-1:0]  s1, s2;
  logic [CNT_W-1:0] cnt   [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  logic [NBTN-1:0]  level_d, rise, fall, press_d;

  // A channel flips only after DB_TICKS consecutive samples disagree with its level.
  always_comb begin
    level_d = level;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      cnt_d[i] = '0;
      if (s2[i] != level[i]) begin
        if (cnt[i] == CntLast) begin
          level_d[i] = s2[i];
          rise[i]    = s2[i];
          fall[i]    = ~s2[i];
        end else begin
          cnt_d[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int unsigned      RPT_W     = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RptDelay  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RptReload = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [RPT_W-1:0] rpt   [NBTN];
  logic [RPT_W-1:0] rpt_d [NBTN];
  logic [NBTN-1:0]  rpt_fire;

  // rpt counts cycles since the last press pulse; firing as it reaches RptDelay
  // puts repeats exactly REPEAT_DELAY, then REPEAT_RATE, cycles apart.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      rpt_d[i] = '0;
      if (level[i] && !fall[i]) begin
        if (rpt[i] + 1'b1 == RptDelay) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RptReload;
        end else begin
          rpt_d[i] = rpt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NBTN); i++) rpt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++) rpt[i] <= rpt_d[i];
    end
  end

  assign press_d = rise | rpt_fire;
`else
  assign press_d = rise;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1            <= '0;
      s2            <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < int'(NBTN); i++) cnt[i] <= '0;
    end else begin
      s1            <= pb_in;
      s2            <= s1;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= fall;
      for (int i = 0; i < int'(NBTN); i++) cnt[i] <= cnt_d[i];
    end
  end

  assign any_held = |level;

endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
- Conditions raw push-button inputs before they reach the digit counters and shift-register enables.
- Per button: 2-FF synchronizer, then a counter-based debouncer.
- Outputs are the debounced level plus single-cycle press/release pulses, all synchronous to clk.
- Sits between the board pb[] pins and the counting/display logic.
- The press pulse replaces raw-button enables and derived clocks with a clean one-cycle enable.

Parameters:
NBTN, 21, number of buttons conditioned (one independent channel per bit)
DB_TICKS, 3, consecutive clk cycles synchronized input must differ from level before level flips; legal range 1..2**CNT_W-1
CNT_W, 4, width of per-channel debounce counter
REPEAT_DELAY, 50, clk cycles from press pulse to first auto-repeat pulse (used only with PB_AUTOREPEAT_EN)
REPEAT_RATE, 10, clk cycles between subsequent auto-repeat pulses (used only with PB_AUTOREPEAT_EN)

Ports:
clk  input  1  system clock (hz100 on the board)
reset  input  1  asynchronous, active-high reset
pb_in  input  NBTN  raw, asynchronous button levels, 1 = pressed
level  output  NBTN  debounced button level, registered
press  output  NBTN  one-cycle pulse on each debounced 0->1 (and auto-repeat when enabled)
release  output  NBTN  one-cycle pulse on each debounced 1->0
any_held  output  1  OR-reduction of level (combinational from level)

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset state: s1, s2, level, press, release, all debounce counters and all repeat counters = 0; any_held = 0.
- Synchronizer: each edge, s1 <= pb_in and s2 <= s1. Only s2 feeds later logic.
- Debounce, per channel i, each rising edge:
  - s2[i] == level[i]: cnt[i] <= 0; press[i] <= 0; release[i] <= 0.
  - s2[i] != level[i] and cnt[i] != DB_TICKS-1: cnt[i] <= cnt[i]+1; pulses 0.
  - s2[i] != level[i] and cnt[i] == DB_TICKS-1: level[i] <= s2[i]; cnt[i] <= 0; press[i] <= s2[i]; release[i] <= ~s2[i].
- Latency:
  - pb_in stable from before edge E0 -> level changes, with press or release high, after edge E0+1+DB_TICKS.
  - Default DB_TICKS=3: level high after the 5th rising edge counting E0.
- Pulse width: press and release are high for exactly one cycle. They never assert together on one channel.
- Glitch rejection: an s2 excursion shorter than DB_TICKS cycles resets cnt, with no change to level and no pulse.
  - The count restarts from 0 on each new excursion and does not accumulate across bounces.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Counter never exceeds DB_TICKS-1; no wrap.
- Reset mid-debounce or mid-hold: all state clears immediately. No release pulse is generated for a button held at reset.
  - A button still held after reset deasserts is re-debounced and produces a fresh press.
- No handshake: consumers sample press as a single-cycle enable.

Optional Feature:
Macro: PB_AUTOREPEAT_EN
- Defined: each channel gets a repeat counter rpt[i], cleared when level[i]==0 and loaded to 0 on the debounce press.
  - While level[i]==1, rpt[i] increments each cycle.
  - When rpt[i]==REPEAT_DELAY, press[i] pulses one cycle and rpt[i] reloads to REPEAT_DELAY-REPEAT_RATE.
  - Net effect: pulses at REPEAT_DELAY, +REPEAT_RATE, +2*REPEAT_RATE, ... after the initial press.
  - Repeat stops in the cycle level falls; release is unaffected.
  - Repeat counter width is sized to hold REPEAT_DELAY.
- Undefined: no repeat logic is present; press fires once per debounced 0->1.

Test Plan:
1. Reset, hold pb_in[0]=1 from before edge 0 -> level[0]=1 and press[0]=1 for exactly one cycle after edge 4; release stays 0; any_held=1 thereafter.
2. pb_in[3] pulsed high for 2 cycles, then low, repeated 5 times -> level[3], press[3] and release[3] stay 0 throughout.
3. pb_in[1] held 20 cycles then dropped -> one press[1] pulse, then a release[1] pulse after edge (drop+4); level[1] low afterward.
4. pb_in[0] and pb_in[20] rise on the same edge -> press[0] and press[20] pulse in the same cycle; level=0x100001.
5. Assert reset while level[2]=1 and pb_in[2] still high -> all outputs 0 immediately with no release pulse; after reset deasserts, press[2] pulses 5 edges later.
6. With PB_AUTOREPEAT_EN, hold pb_in[5] for 100 cycles past press -> press[5] pulses at +0, +50, +60, +70, +80, +90, +100; none after the drop.
